// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column strobing, whole-matrix debounce,
// single-key press events delivered over a valid/ack handshake.
module keypad_scanner #(
    parameter int SCAN_BITS      = 17,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       fpgaClk,
    input  logic       reset_n,
    input  logic [3:0] ROW,
    output logic [3:0] COL,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       key_pressed,
    output logic       overrun
);

    localparam int MW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [MW-1:0] MATCH_MAX = MW'(DEBOUNCE_SCANS);
    localparam logic [MW-1:0] MATCH_ONE = MW'(1);

    logic [3:0]           row_meta_q;
    logic [3:0]           row_sync_q;
    logic [SCAN_BITS-1:0] dwell_q;
    logic [SCAN_BITS-1:0] dwell_d;
    logic [1:0]           col_idx_q;
    logic [1:0]           col_idx_d;
    logic [3:0]           col_q;
    logic [3:0]           col_d;
    logic [15:0]          snap_q;
    logic [15:0]          snap_d;
    logic [15:0]          prev_q;
    logic [15:0]          prev_d;
    logic [15:0]          stable_q;
    logic [15:0]          stable_d;
    logic [MW-1:0]        match_q;
    logic [MW-1:0]        match_d;
    logic [3:0]           code_q;
    logic [3:0]           code_d;
    logic                 valid_q;
    logic                 valid_d;
    logic                 ovr_q;
    logic                 ovr_d;
    logic                 pressed_q;
    logic                 pressed_d;

    logic                 sample;
    logic                 complete;
    logic                 accept;
    logic                 one_key;
    logic                 event_w;
    logic [3:0]           ev_code;

    assign sample   = &dwell_q;
    assign complete = sample && (col_idx_q == 2'd3);

    always_comb begin
        dwell_d   = dwell_q + SCAN_BITS'(1);
        col_idx_d = col_idx_q;
        if (sample) begin
            col_idx_d = col_idx_q + 2'd1;
        end
        col_d = ~(4'b0001 << col_idx_d);
    end

    // Rows are inverted here so that a set snapshot bit means "pressed".
    always_comb begin
        snap_d = snap_q;
        if (sample) begin
            snap_d[{col_idx_q, 2'b00} +: 4] = ~row_sync_q;
        end
    end

    always_comb begin
        match_d = match_q;
        prev_d  = prev_q;
        if (complete) begin
            prev_d = snap_d;
            if (snap_d == prev_q) begin
                if (match_q != MATCH_MAX) begin
                    match_d = match_q + MATCH_ONE;
                end
            end else begin
                match_d = MATCH_ONE;
            end
        end
    end

    assign accept   = complete && (match_d == MATCH_MAX);
    assign stable_d = accept ? snap_d : stable_q;
    assign one_key  = (snap_d != 16'd0) &&
                      ((snap_d & (snap_d - 16'd1)) == 16'd0);
    assign event_w  = accept && (stable_q == 16'd0) && one_key;

    // Bit index b = col*4 + row maps to code {row, col}.
    always_comb begin
        ev_code = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (snap_d[i]) begin
                ev_code = {i[1:0], i[3:2]};
            end
        end
    end

    // An ack is applied first, so a same-cycle event lands in a free slot.
    always_comb begin
        valid_d = valid_q;
        ovr_d   = ovr_q;
        code_d  = code_q;
        if (key_ack && valid_q) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
        if (event_w) begin
            if (valid_d) begin
                ovr_d = 1'b1;
            end else begin
                valid_d = 1'b1;
                code_d  = ev_code;
            end
        end
        pressed_d = (stable_d != 16'd0);
    end

    always_ff @(posedge fpgaClk) begin
        if (!reset_n) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
            dwell_q    <= '0;
            col_idx_q  <= 2'd0;
            col_q      <= 4'b1110;
            snap_q     <= 16'd0;
            prev_q     <= 16'd0;
            stable_q   <= 16'd0;
            match_q    <= '0;
            code_q     <= 4'd0;
            valid_q    <= 1'b0;
            ovr_q      <= 1'b0;
            pressed_q  <= 1'b0;
        end else begin
            row_meta_q <= ROW;
            row_sync_q <= row_meta_q;
            dwell_q    <= dwell_d;
            col_idx_q  <= col_idx_d;
            col_q      <= col_d;
            snap_q     <= snap_d;
            prev_q     <= prev_d;
            stable_q   <= stable_d;
            match_q    <= match_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
            ovr_q      <= ovr_d;
            pressed_q  <= pressed_d;
        end
    end

    assign COL         = col_q;
    assign key_code    = code_q;
    assign key_valid   = valid_q;
    assign key_pressed = pressed_q;
    assign overrun     = ovr_q;

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 matrix keypad on the board's row/column header and delivers debounced key presses to the core through a valid/ack handshake. It is the input-side counterpart of the multiplexed seven-segment display path. It sequentially drives one active-low column strobe at a time, reads the active-low row lines, debounces whole-matrix snapshots, and emits one event per fresh single-key press.

## Interface
- SCAN_BITS, default 17: per-column dwell is 2^SCAN_BITS clocks (1.31 ms at 100 MHz); legal range >= 2.
- DEBOUNCE_SCANS, default 4: number of consecutive identical full-matrix snapshots required before acceptance; legal range >= 2.
- fpgaClk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- ROW  in  4  keypad rows, active-low (pulled up), asynchronous to fpgaClk.
- COL  out  4  column strobes, exactly one bit low at all times.
- key_code  out  4  code of the last accepted key, {row_idx[1:0], col_idx[1:0]}.
- key_valid  out  1  high while an event awaits acknowledgement.
- key_ack  in  1  consumer acknowledge, sampled each clock.
- key_pressed  out  1  high while the accepted (debounced) snapshot is non-zero.
- overrun  out  1  sticky flag: a press event was dropped while key_valid was high.

## Operation
- ROW passes through a 2-flop synchronizer and is inverted, giving 1 = pressed.
- Dwell counter is SCAN_BITS wide and free-running. Column index (2 bits) advances when the counter wraps from all-ones to 0.
- COL mapping: idx 0 = 4'b1110, idx 1 = 4'b1101, idx 2 = 4'b1011, idx 3 = 4'b0111.
- Sample point: the cycle in which the dwell counter is all-ones. The synchronized rows are written into snapshot bits [idx*4 +: 4], with bit idx*4+r = row r.
- A snapshot is complete at the column-3 sample point. On completion:
  - equal to the previous completed snapshot: match_cnt increments, saturating;
  - otherwise: match_cnt = 1.
  - The completed snapshot becomes the previous snapshot.
- Acceptance: when match_cnt reaches DEBOUNCE_SCANS, the snapshot is loaded into the stable register.
- Press event: the stable register changes from all-zero to exactly one bit set. key_code is the index of that bit, converted to {row, col}.
- No press event is generated for:
  - transitions into multi-key states;
  - changes from one non-zero state to another.
  - The stable register must return to zero before the next event.
- Handshake:
  - The event sets key_valid and loads key_code.
  - key_valid stays high, with key_code held, until key_ack is sampled high. key_valid then goes low on the next edge.
  - key_ack while key_valid is low is ignored.
- Event while key_valid is high: the event is dropped, key_code is unchanged, and overrun is set.
  - overrun clears on the edge where key_ack is sampled with key_valid high.
  - Same-cycle event and ack: the ack clears key_valid and overrun, then the new event sets key_valid and loads the new key_code. The net result is key_valid high with the new code and overrun low.

## Timing
- Reset values: COL = 4'b1110, key_code = 0, key_valid = 0, key_pressed = 0, overrun = 0. Dwell counter, column index, snapshots, match_cnt and stable register all reset to 0.
- Reset mid-scan or with key_valid high aborts everything; the next cycle matches the reset state exactly.
- Full scan period: 4 * 2^SCAN_BITS clocks.
- Press-to-key_valid latency, for a key held steady: at most (DEBOUNCE_SCANS + 1) full scans + 3 clocks, and at least (DEBOUNCE_SCANS - 1) full scans.
- key_valid and key_pressed update on the edge after the column-3 sample cycle of the accepting scan.
- Release latency for key_pressed follows the same bounds.
- No combinational path from any input to any output.

## Test plan
- **Reset and idle.** SCAN_BITS = 2, DEBOUNCE_SCANS = 3, reset_n low for 3 clocks, ROW = 4'hF.
  - COL cycles 1110, 1101, 1011, 0111, each for 4 clocks (16-clock period).
  - key_valid, key_pressed and overrun stay 0 for 200 clocks.
- **Single press.** Drive ROW[2] low only while COL = 4'b1101.
  - key_valid rises within 4 scans (67 clocks) with key_code = 4'b1001.
  - key_pressed = 1.
  - key_ack pulse makes key_valid 0 on the next clock.
- **Bounce.** Toggle the key every 10 clocks for 100 clocks, then hold it.
  - No event during bouncing.
  - Exactly one event after settling.
  - Release produces no event, and key_pressed falls.
- **Multi-key.** Press keys 0 and 5 together.
  - key_pressed = 1, no event.
  - Release key 5 only: still no event.
  - Release all, then press key 3: one event with key_code = 4'b1100.
- **Overrun.** Two separate presses with no ack in between.
  - key_code keeps the first code and overrun = 1.
  - key_ack clears both key_valid and overrun.
- **Mid-operation reset.** Pulse reset_n low with key_valid high and the scan at column 2.
  - All outputs are at their reset values on the next clock.
  - The held key re-triggers one event after debounce.
